// File: rtl/uart_fifo_periph.sv
// uart_fifo_periph: memory-mapped UART with TX/RX FIFOs, baud divisor, sticky errors and level irq.
// Define UART_LOOPBACK_EN to implement CTRL[20] internal loopback.
module uart_fifo_periph #(
   parameter int DATA_BITS = 8,
   parameter int TX_DEPTH  = 8,
   parameter int RX_DEPTH  = 8,
   parameter int DIV_RESET = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  sel,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        rx,
   output logic        tx,
   output logic        irq
);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam logic [3:0] LAST = 4'(DATA_BITS - 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [DATA_BITS-1:0] tx_mem_q [TX_DEPTH];
   logic [DATA_BITS-1:0] rx_mem_q [RX_DEPTH];
   logic [TAW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, tx_cnt;
   logic [RAW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d, rx_cnt;
   logic [15:0] div_q, div_d, tx_div_q, tx_div_d, rx_div_q, rx_div_d;
   logic [15:0] tx_tick_q, tx_tick_d, rx_tick_q, rx_tick_d;
   logic [3:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
   state_t tx_st_q, tx_st_d, rx_st_q, rx_st_d;
   logic tx_en_q, tx_en_d, rx_en_q, rx_en_d, rxie_q, rxie_d, txie_q, txie_d, lb_q, lb_d;
   logic rx_ovr_q, rx_ovr_d, ferr_q, ferr_d, tx_ovf_q, tx_ovf_d;
   logic ser_q, ser_d, busy_q, busy_d, irq_q, irq_d;
   logic s1_q, s2_q, s3_q, rx_in;
   logic [31:0] rdata_q, rdata_d, status, ctrl;
   logic tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;
   logic rx_valid, rx_bad, tx_end, rx_end, wr_data, wr_stat, wr_ctrl;
   logic unused_wdata;

   assign unused_wdata = ^wdata[31:20];
   assign tx_cnt   = tx_wp_q - tx_rp_q;
   assign rx_cnt   = rx_wp_q - rx_rp_q;
   assign tx_empty = tx_wp_q == tx_rp_q;
   assign rx_empty = rx_wp_q == rx_rp_q;
   assign tx_full  = tx_wp_q[TAW] != tx_rp_q[TAW] && tx_wp_q[TAW-1:0] == tx_rp_q[TAW-1:0];
   assign rx_full  = rx_wp_q[RAW] != rx_rp_q[RAW] && rx_wp_q[RAW-1:0] == rx_rp_q[RAW-1:0];
   assign wr_data  = wr_en && sel == 2'd0;
   assign wr_stat  = wr_en && sel == 2'd1;
   assign wr_ctrl  = wr_en && sel == 2'd2;
   assign tx_push  = wr_data && !tx_full;
   assign rx_pop   = rd_en && sel == 2'd0 && !rx_empty;
   // A pop on the same edge frees the slot, so a full FIFO can still accept the push.
   assign rx_push  = rx_valid && (!rx_full || rx_pop);
   assign tx_end   = tx_tick_q == tx_div_q - 16'd1;
   assign rx_end   = rx_tick_q == rx_div_q - 16'd1;
   assign status   = {8'(tx_cnt), 8'(rx_cnt), 8'd0, tx_ovf_q, ferr_q, rx_ovr_q, busy_q,
                      rx_full, rx_empty, tx_empty, tx_full};
   assign ctrl     = {11'd0, lb_q, txie_q, rxie_q, rx_en_q, tx_en_q, div_q};
   assign rdata    = rdata_q;
   assign irq      = irq_q;
`ifdef UART_LOOPBACK_EN
   assign rx_in = lb_q ? ser_q : rx;
   assign tx    = lb_q ? 1'b1 : ser_q;
`else
   assign rx_in = rx;
   assign tx    = ser_q;
`endif

   always_comb begin
      div_d = wr_ctrl ? (wdata[15:0] < 16'd4 ? 16'd4 : wdata[15:0]) : div_q;
      {txie_d, rxie_d, rx_en_d, tx_en_d} = wr_ctrl ? wdata[19:16] : {txie_q, rxie_q, rx_en_q, tx_en_q};
`ifdef UART_LOOPBACK_EN
      lb_d = wr_ctrl ? wdata[20] : lb_q;
`else
      lb_d = 1'b0;
`endif
      rx_ovr_d = (rx_ovr_q && !(wr_stat && wdata[5])) || (rx_valid && rx_full && !rx_pop);
      ferr_d   = (ferr_q && !(wr_stat && wdata[6])) || rx_bad;
      tx_ovf_d = (tx_ovf_q && !(wr_stat && wdata[7])) || (wr_data && tx_full);
      tx_wp_d  = tx_wp_q + (TAW+1)'(tx_push);
      tx_rp_d  = tx_rp_q + (TAW+1)'(tx_pop);
      rx_wp_d  = rx_wp_q + (RAW+1)'(rx_push);
      rx_rp_d  = rx_rp_q + (RAW+1)'(rx_pop);
      rdata_d  = !rd_en ? rdata_q : sel == 2'd0 ? (rx_empty ? 32'd0 : 32'(rx_mem_q[rx_rp_q[RAW-1:0]])) :
                 sel == 2'd1 ? status : sel == 2'd2 ? ctrl : 32'd0;
      irq_d    = (rxie_q && (!rx_empty || rx_ovr_q || ferr_q)) || (txie_q && tx_empty && !busy_q);
   end

   always_comb begin
      tx_st_d   = tx_st_q;
      tx_tick_d = tx_tick_q + 16'd1;
      tx_bit_d  = tx_bit_q;
      tx_sh_d   = tx_sh_q;
      tx_div_d  = tx_div_q;
      tx_pop    = 1'b0;
      unique case (tx_st_q)
         IDLE:  tx_tick_d = '0;
         START: if (tx_end) begin
            tx_st_d   = DATA;
            tx_tick_d = '0;
         end
         DATA:  if (tx_end) begin
            tx_tick_d = '0;
            tx_sh_d   = tx_sh_q >> 1;
            tx_bit_d  = tx_bit_q + 4'd1;
            tx_st_d   = tx_bit_q == LAST ? STOP : DATA;
         end
         STOP:  if (tx_end) begin
            tx_st_d   = IDLE;
            tx_tick_d = '0;
         end
      endcase
      // Chaining straight from STOP into START keeps back-to-back frames gapless.
      if ((tx_st_q == IDLE || (tx_st_q == STOP && tx_end)) && tx_en_q && !tx_empty) begin
         tx_st_d   = START;
         tx_pop    = 1'b1;
         tx_sh_d   = tx_mem_q[tx_rp_q[TAW-1:0]];
         tx_div_d  = div_q;
         tx_bit_d  = '0;
         tx_tick_d = '0;
      end
      ser_d  = tx_st_q == START ? 1'b0 : tx_st_q == DATA ? tx_sh_q[0] : 1'b1;
      busy_d = tx_st_q != IDLE;
   end

   always_comb begin
      rx_st_d   = rx_st_q;
      rx_tick_d = rx_tick_q + 16'd1;
      rx_bit_d  = rx_bit_q;
      rx_sh_d   = rx_sh_q;
      rx_div_d  = rx_div_q;
      rx_valid  = 1'b0;
      rx_bad    = 1'b0;
      unique case (rx_st_q)
         IDLE:  begin
            rx_tick_d = '0;
            if (rx_en_q && s3_q && !s2_q) begin
               rx_st_d  = START;
               rx_div_d = div_q;
            end
         end
         START: if (rx_tick_q == (rx_div_q >> 1) - 16'd1) begin
            rx_tick_d = '0;
            rx_bit_d  = '0;
            rx_st_d   = s2_q ? IDLE : DATA;
         end
         DATA:  if (rx_end) begin
            rx_tick_d = '0;
            rx_sh_d   = {s2_q, rx_sh_q[DATA_BITS-1:1]};
            rx_bit_d  = rx_bit_q + 4'd1;
            rx_st_d   = rx_bit_q == LAST ? STOP : DATA;
         end
         STOP:  if (rx_end) begin
            rx_st_d  = IDLE;
            rx_valid = s2_q;
            rx_bad   = !s2_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wp_q <= '0; tx_rp_q <= '0; rx_wp_q <= '0; rx_rp_q <= '0;
         div_q <= 16'(DIV_RESET); tx_div_q <= 16'(DIV_RESET); rx_div_q <= 16'(DIV_RESET);
         tx_tick_q <= '0; rx_tick_q <= '0; tx_bit_q <= '0; rx_bit_q <= '0;
         tx_sh_q <= '0; rx_sh_q <= '0; tx_st_q <= IDLE; rx_st_q <= IDLE;
         tx_en_q <= 1'b1; rx_en_q <= 1'b1; rxie_q <= 1'b0; txie_q <= 1'b0; lb_q <= 1'b0;
         rx_ovr_q <= 1'b0; ferr_q <= 1'b0; tx_ovf_q <= 1'b0;
         ser_q <= 1'b1; busy_q <= 1'b0; irq_q <= 1'b0; rdata_q <= '0;
         s1_q <= 1'b1; s2_q <= 1'b1; s3_q <= 1'b1;
      end else begin
         tx_wp_q <= tx_wp_d; tx_rp_q <= tx_rp_d; rx_wp_q <= rx_wp_d; rx_rp_q <= rx_rp_d;
         div_q <= div_d; tx_div_q <= tx_div_d; rx_div_q <= rx_div_d;
         tx_tick_q <= tx_tick_d; rx_tick_q <= rx_tick_d; tx_bit_q <= tx_bit_d; rx_bit_q <= rx_bit_d;
         tx_sh_q <= tx_sh_d; rx_sh_q <= rx_sh_d; tx_st_q <= tx_st_d; rx_st_q <= rx_st_d;
         tx_en_q <= tx_en_d; rx_en_q <= rx_en_d; rxie_q <= rxie_d; txie_q <= txie_d; lb_q <= lb_d;
         rx_ovr_q <= rx_ovr_d; ferr_q <= ferr_d; tx_ovf_q <= tx_ovf_d;
         ser_q <= ser_d; busy_q <= busy_d; irq_q <= irq_d; rdata_q <= rdata_d;
         s1_q <= rx_in; s2_q <= s1_q; s3_q <= s2_q;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wp_q[TAW-1:0]] <= wdata[DATA_BITS-1:0];
      if (rx_push) rx_mem_q[rx_wp_q[RAW-1:0]] <= rx_sh_q;
   end
endmodule

// File: tb/tb_uart_fifo_periph.sv
// tb_uart_fifo_periph: scoreboard bench for uart_fifo_periph (TX decoder monitor, RX frame driver).
module tb_uart_fifo_periph;
   logic clk = 1'b0, reset, wr_en, rd_en, rx, tx, irq;
   logic [1:0] sel;
   logic [31:0] wdata, rdata, r;
   int pass_cnt = 0, total = 0, cyc = 0, bdiv = 4;
   logic [7:0] txq[$], rxq[$];
   int starts[$];
   bit mon_on = 1'b1;
   logic [7:0] m_b;
   logic m_ok, low_seen;
   logic [9:0] frame;

   uart_fifo_periph dut (.clk(clk), .reset(reset), .sel(sel), .wr_en(wr_en), .rd_en(rd_en),
      .wdata(wdata), .rdata(rdata), .rx(rx), .tx(tx), .irq(irq));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] s, input logic [31:0] d);
      sel = s; wdata = d; wr_en = 1'b1;
      step();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [1:0] s, output logic [31:0] d);
      sel = s; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      d = rdata;
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      if (stop && rxq.size() < 8) rxq.push_back(b);
      rx = 1'b0;
      step(bdiv);
      for (int k = 0; k < 8; k++) begin
         rx = b[k];
         step(bdiv);
      end
      rx = stop;
      step(bdiv);
      rx = 1'b1;
      step(4);
   endtask

   initial forever begin
      @(posedge clk);
      #2;
      if (mon_on && tx === 1'b0) begin
         starts.push_back(cyc);
         repeat (bdiv / 2) @(posedge clk);
         #2;
         m_ok = tx === 1'b0;
         for (int k = 0; k < 8; k++) begin
            repeat (bdiv) @(posedge clk);
            #2;
            m_b[k] = tx;
         end
         repeat (bdiv) @(posedge clk);
         #2;
         m_ok = m_ok && tx === 1'b1;
         check("tx_frame_expected", 32'(txq.size() > 0), 32'd1);
         check("tx_byte", 32'(m_b), txq.size() > 0 ? 32'(txq.pop_front()) : 32'hxx);
         check("tx_framing", 32'(m_ok), 32'd1);
      end
   end

   initial begin
      reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; sel = 2'd0; wdata = '0; rx = 1'b1;
      step(3);
      reset = 1'b0;
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      rd(2'd1, r); check("rst_status", r, 32'h0000_0006);
      rd(2'd2, r); check("rst_ctrl", r, 32'h0003_01B2);
      wr(2'd2, 32'h0003_0001); bdiv = 4;
      rd(2'd2, r); check("div_clamp", r, 32'h0003_0004);

      frame = {1'b1, 8'hA5, 1'b0};
      txq.push_back(8'hA5);
      wr(2'd0, 32'h0000_00A5);
      check("tx_idle_n", 32'(tx), 32'd1);
      sel = 2'd1; rd_en = 1'b1;
      step();
      check("tx_idle_n1", 32'(tx), 32'd1);
      for (int i = 0; i < 40; i++) begin
         step();
         check("tx_bit", 32'(tx), 32'(frame[i / 4]));
         if (i > 0) check("tx_busy", 32'(rdata[4]), 32'd1);
      end
      rd_en = 1'b0;
      step(10);
      rd(2'd1, r); check("tx_done_status", r, 32'h0000_0006);

      wr(2'd2, 32'h0002_0004);
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) txq.push_back(8'(i));
         wr(2'd0, 32'(i));
      end
      rd(2'd1, r); check("tx_ovf_status", r, 32'h0800_0085);
      starts.delete();
      wr(2'd2, 32'h0003_0004);
      step(8 * 40 + 20);
      check("tx_drain", 32'(txq.size()), 32'd0);
      check("tx_frames", 32'(starts.size()), 32'd8);
      for (int i = 0; i + 1 < starts.size(); i++) check("tx_gap", 32'(starts[i+1] - starts[i]), 32'd40);
      wr(2'd1, 32'h0000_0080);
      rd(2'd1, r); check("tx_ovf_w1c", r, 32'h0000_0006);

      wr(2'd2, 32'h0003_0008); bdiv = 8;
      send(8'h3C, 1'b1);
      rd(2'd1, r); check("rx_one_status", r, 32'h0001_0002);
      rd(2'd0, r); check("rx_data", r, 32'(rxq.pop_front()));
      rd(2'd1, r); check("rx_empty_after", r, 32'h0000_0006);

      for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 1'b1);
      rd(2'd1, r); check("rx_ovr_status", r, 32'h0008_002A);
      for (int i = 0; i < 9; i++) begin
         rd(2'd0, r);
         check("rx_ovr_data", r, rxq.size() > 0 ? 32'(rxq.pop_front()) : 32'd0);
      end
      wr(2'd1, 32'h0000_0020);

      send(8'h55, 1'b0);
      rd(2'd1, r); check("ferr_status", r, 32'h0000_0046);
      rx = 1'b0; step(); rx = 1'b1; step(20);
      rd(2'd1, r); check("glitch_status", r, 32'h0000_0046);
      wr(2'd1, 32'h0000_0040);
      rd(2'd1, r); check("ferr_w1c", r, 32'h0000_0006);

      wr(2'd2, 32'h0013_0004); bdiv = 4;
`ifdef UART_LOOPBACK_EN
      wr(2'd0, 32'h0000_005A);
      low_seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (tx !== 1'b1) low_seen = 1'b1;
      end
      check("lb_pin_high", 32'(low_seen), 32'd0);
      rd(2'd0, r); check("lb_data", r, 32'h0000_005A);
`else
      rd(2'd2, r); check("lb_absent", r, 32'h0003_0004);
`endif
      wr(2'd2, 32'h000B_0004);
      step(2); check("irq_tx", 32'(irq), 32'd1);
      wr(2'd2, 32'h0007_0004);
      step(2); check("irq_rx_idle", 32'(irq), 32'd0);
      send(8'h77, 1'b1);
      step(2); check("irq_rx", 32'(irq), 32'd1);

      mon_on = 1'b0;
      wr(2'd0, 32'h0000_0099);
      step(10);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_mid_tx", 32'(tx), 32'd1);
      check("rst_mid_irq", 32'(irq), 32'd0);
      rd(2'd1, r); check("rst_mid_status", r, 32'h0000_0006);
      rd(2'd2, r); check("rst_mid_ctrl", r, 32'h0003_01B2);
      step(20);
      check("rst_mid_tx_idle", 32'(tx), 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/uart_fifo_periph.md
# uart_fifo_periph

Parametrised memory-mapped UART peripheral for the multi-cycle RISC-V system. It replaces the single-register UART path with independent TX and RX FIFOs, a programmable baud divisor, sticky error flags and a level interrupt. The processor core accesses it through a 4-register interface, and it drives the board's `tx`/`rx` pins.

## Interface
- `DATA_BITS`, 8: payload bits per frame, 5–8.
- `TX_DEPTH`, 8: TX FIFO entries, power of two, 2–128.
- `RX_DEPTH`, 8: RX FIFO entries, power of two, 2–128.
- `DIV_RESET`, 434: baud divisor at reset (clk cycles per bit).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sel`  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved (reads 0, writes ignored).
- `wr_en`  in  1  write strobe for the register at `sel`.
- `rd_en`  in  1  read strobe for the register at `sel`.
- `wdata`  in  32  write data.
- `rdata`  out  32  registered read data.
- `rx`  in  1  serial input, asynchronous.
- `tx`  out  1  serial output; idles high.
- `irq`  out  1  registered level interrupt.

## Operation
- DATA write: pushes `wdata[DATA_BITS-1:0]` into TX FIFO. If the FIFO is full, the write is dropped and sticky `tx_ovf` is set.
- DATA read: pops the RX FIFO into `rdata`, zero-extended. If the FIFO is empty, `rdata`=0 and no pop occurs.
- STATUS bits:
  - [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full
  - [4] tx_busy, [5] rx_ovr, [6] frame_err, [7] tx_ovf
  - [23:16] rx_count, [31:24] tx_count
- STATUS write: W1C on bits [7:5]; all other bits are ignored.
- CTRL bits: [15:0] divisor, [16] tx_en, [17] rx_en, [18] rx_irq_en, [19] tx_irq_en, [20] loopback.
  - Divisor writes below 4 store 4.
- Divisor changes take effect at the next frame boundary. A frame in flight completes at the old rate.
- TX FSM: IDLE → START → DATA (LSB first, DATA_BITS bits) → STOP → IDLE.
  - Each bit lasts exactly `divisor` cycles.
  - The FSM leaves IDLE only when tx_en=1 and the TX FIFO is non-empty.
  - Clearing tx_en mid-frame completes the current frame.
- RX path:
  - `rx` passes through a 2-flop synchroniser.
  - FSM: IDLE → START → DATA → STOP.
  - A falling edge in IDLE (with rx_en=1) starts a half-divisor wait; the line is re-checked there. If it is high, the FSM returns to IDLE (glitch reject).
  - Data and stop bits are then sampled every `divisor` cycles.
  - Stop bit = 0: the byte is discarded and frame_err is set.
  - Valid byte with FIFO full: the byte is dropped and rx_ovr is set. If a pop and a push occur on the same edge with the FIFO full, the pop applies first and the push succeeds (no overrun).
- `irq` = (rx_irq_en & (!rx_empty | rx_ovr | frame_err)) | (tx_irq_en & tx_empty & !tx_busy), registered.
- Reset values:
  - `tx`=1, `rdata`=0, `irq`=0.
  - FIFOs empty, sticky bits 0.
  - divisor=DIV_RESET, tx_en=1, rx_en=1, irq enables 0, loopback 0.
  - Both FSMs in IDLE. Reset mid-frame aborts the frame; `tx` is high from the first edge after reset is sampled.

## Timing
- Register write takes effect on the edge where `wr_en` is sampled.
- `rdata` is valid the cycle after `rd_en`, and holds its value until the next read.
- Counts in STATUS reflect FIFO state after that same edge.
- Simultaneous `rd_en` and `wr_en` are allowed: the write is applied, and the read returns pre-write values.
- TX latency: with the FIFO empty and the FSM idle, a DATA write at edge N drives the start bit on `tx` from edge N+2.
  - The frame occupies exactly (DATA_BITS+2)×divisor cycles.
  - Back-to-back frames add no idle gap.
- RX latency: rx_count increments 2 cycles after the stop-bit sample point. This accounts for the synchroniser delay plus one cycle.
- tx_count and rx_count saturate their 8-bit fields only by parameter bounds; no wrap is possible.
- FIFO pointers wrap modulo depth, with one extra bit for full/empty.

## Configuration
- `UART_LOOPBACK_EN` defined: CTRL[20] is implemented. When it is set, the RX input is the TX serializer output (before the pin), and `tx` is held at 1.
- Not defined: CTRL[20] is not implemented, reads 0, and writes to it are ignored; RX is always driven from `rx`.

## Test plan
- Basic TX: divisor=4, write DATA=0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit, start bit from edge N+2, tx_busy=1 throughout.
- TX overflow: tx_en=0, 9 writes 0x01..0x09 → tx_count=8, tx_ovf=1. Set tx_en=1 → frames 0x01..0x08 sent with no gap. W1C 0x80 → tx_ovf=0.
- Basic RX: drive frame 0x3C at divisor=8 → rx_count=1. Read DATA → `rdata`=0x0000003C, rx_empty=1.
- RX overrun: 9 frames 0x10..0x18 with no reads → rx_ovr=1. Reads return 0x10..0x17, then 0.
- Frame error plus glitch: frame with stop=0 → frame_err=1, rx_count unchanged. A 1-cycle low glitch on `rx` → no frame.
- Loopback (macro on): CTRL[20]=1, write 0x5A → read DATA returns 0x5A, pin `tx` stays 1. Assert reset mid-frame → `tx`=1, counts 0, `irq`=0.
